// File: rtl/xge_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xge_wb_pkg
// Purpose  : Shared types and xge_mac register map for the Wishbone config master
// Revision : 1.0 - initial release
// ============================================================================
package xge_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_mst_state_t;

    // xge_mac register slave address map
    localparam logic [7:0] XGE_ADR_CONFIG0     = 8'h00;
    localparam logic [7:0] XGE_ADR_INT_PENDING = 8'h08;
    localparam logic [7:0] XGE_ADR_INT_STATUS  = 8'h0C;
    localparam logic [7:0] XGE_ADR_INT_MASK    = 8'h10;

endpackage
`default_nettype wire

// File: rtl/xge_wb_cfg_master.sv
`default_nettype none
// ============================================================================
// Module   : xge_wb_cfg_master
// Purpose  : Wishbone classic single-transfer master with bus timeout and
//            sticky interrupt capture for the xge_mac register slave
// Revision : 1.0 - initial release
// ============================================================================
module xge_wb_cfg_master #(
    parameter int ADR_W          = 8,
    parameter int DAT_W          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [DAT_W-1:0] cmd_dat,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DAT_W-1:0] rsp_dat,
    output logic             rsp_err,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [ADR_W-1:0] wb_adr_o,
    output logic [DAT_W-1:0] wb_dat_o,
    input  logic [DAT_W-1:0] wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_int_i,
    output logic             irq_pending,
    input  logic             irq_clr
);
    import xge_wb_pkg::*;

    localparam int                 c_CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    wb_mst_state_t      r_state;
    wb_mst_state_t      w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_cyc;
    logic               r_we;
    logic [ADR_W-1:0]   r_adr;
    logic [DAT_W-1:0]   r_dat_o;
    logic               r_rsp_valid;
    logic [DAT_W-1:0]   r_rsp_dat;
    logic               r_rsp_err;
    logic               r_irq;
    logic               r_int_d;

    logic               w_accept;
    logic               w_ack;
    logic               w_timeout;
    logic               w_rsp_hs;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ack       = 1'b0;
        w_timeout   = 1'b0;
        w_rsp_hs    = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = cmd_valid;
                if (cmd_valid) w_state_nxt = BUS;
            end
            BUS: begin
                // ack has priority over an expiring timeout in the same cycle
                w_ack     = wb_ack_i;
                w_timeout = !wb_ack_i && (r_cnt == c_CNT_LAST);
                if (wb_ack_i || w_timeout) w_state_nxt = RESP;
            end
            RESP: begin
                w_rsp_hs = rsp_ready;
                if (rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cnt       <= '0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat_o     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cyc   <= 1'b1;
                r_we    <= cmd_we;
                r_adr   <= cmd_adr;
                r_dat_o <= cmd_dat;
            end
            if (w_ack || w_timeout) begin
                r_cyc       <= 1'b0;
                r_we        <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_timeout;
                r_rsp_dat   <= (w_ack && !r_we) ? wb_dat_i : '0;
            end
            if (r_state == BUS && !w_ack && !w_timeout) r_cnt <= r_cnt + 1'b1;
            if (w_rsp_hs) begin
                r_rsp_valid <= 1'b0;
                r_cnt       <= '0;
            end
        end
    end

    // Rising-edge detect: a level held high after a clear does not re-arm
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_int_d <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_int_d <= wb_int_i;
            if (wb_int_i && !r_int_d) r_irq <= 1'b1;
            else if (irq_clr)         r_irq <= 1'b0;
        end
    end

    assign cmd_ready   = (r_state == IDLE);
    assign wb_cyc_o    = r_cyc;
    assign wb_stb_o    = r_cyc;
    assign wb_we_o     = r_we;
    assign wb_adr_o    = r_adr;
    assign wb_dat_o    = r_dat_o;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_dat     = r_rsp_dat;
    assign rsp_err     = r_rsp_err;
    assign irq_pending = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_xge_wb_cfg_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_xge_wb_cfg_master
// Purpose  : Self-checking bench: transaction-level model plus directed vectors
// Revision : 1.0 - initial release
// ============================================================================
module tb_xge_wb_cfg_master;
    import xge_wb_pkg::*;

    localparam int TMO = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [7:0]  cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [7:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_int_i = 1'b0;
    logic        irq_pending;
    logic        irq_clr = 1'b0;

    always #5 wb_clk_i = ~wb_clk_i;

    xge_wb_cfg_master #(.ADR_W(8), .DAT_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_int_i(wb_int_i),
        .irq_pending(irq_pending), .irq_clr(irq_clr)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc_n   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    // Register slave: acks when the strobe has been up for ack_lat+1 cycles
    logic [31:0] mem [0:255];
    int  stb_age   = 0;
    int  ack_lat   = 1;
    bit  ack_en    = 1'b1;
    bit  stray_ack = 1'b0;

    initial for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;

    always @(negedge wb_clk_i) begin
        #1;
        if (wb_cyc_o && wb_stb_o) stb_age++;
        else                      stb_age = 0;
        wb_ack_i = stray_ack || (ack_en && wb_cyc_o && wb_stb_o && stb_age == ack_lat + 1);
        wb_dat_i = mem[wb_adr_o];
    end

    always @(posedge wb_clk_i)
        if (!wb_rst_i && wb_cyc_o && wb_stb_o && wb_ack_i && wb_we_o) mem[wb_adr_o] = wb_dat_o;

    // Transaction-level model: one open bus transfer and/or one outstanding response
    bit          m_open = 0, m_out = 0, m_err = 0, m_irq = 0, m_int_prev = 0;
    logic        m_we = 0;
    logic [7:0]  m_adr = '0;
    logic [31:0] m_dat = '0, m_rsp_dat = '0;
    int          m_age = 0;
    int          cyc_hi = 0, rise_cyc = 0, acc_cyc = 0;
    bit          prev_rv = 0;

    always @(posedge wb_clk_i) begin
        cyc_n++;
        if (wb_rst_i) begin
            m_open = 0; m_out = 0; m_err = 0; m_irq = 0; m_int_prev = 0;
            m_we = 0; m_adr = '0; m_dat = '0; m_rsp_dat = '0; m_age = 0;
        end else begin
            m_irq      = (wb_int_i && !m_int_prev) || (m_irq && !irq_clr);
            m_int_prev = wb_int_i;
            if (m_out) begin
                if (rsp_ready) m_out = 0;
            end else if (m_open) begin
                if (wb_ack_i || m_age == TMO - 1) begin
                    m_err     = !wb_ack_i;
                    m_rsp_dat = (wb_ack_i && !m_we) ? wb_dat_i : 32'h0;
                    m_open    = 0;
                    m_we      = 0;
                    m_out     = 1;
                end else begin
                    m_age++;
                end
            end else if (cmd_valid) begin
                m_open = 1; m_age = 0;
                m_we = cmd_we; m_adr = cmd_adr; m_dat = cmd_dat;
            end
        end
        #1;
        chk("cyc",       wb_cyc_o,    m_open);
        chk("stb",       wb_stb_o,    m_open);
        chk("we",        wb_we_o,     m_we);
        chk("adr",       wb_adr_o,    m_adr);
        chk("dat_o",     wb_dat_o,    m_dat);
        chk("rsp_valid", rsp_valid,   m_out);
        chk("rsp_dat",   rsp_dat,     m_rsp_dat);
        chk("rsp_err",   rsp_err,     m_err);
        chk("irq",       irq_pending, m_irq);
        chk("cmd_ready", cmd_ready,   !m_open && !m_out);
        if (wb_cyc_o) cyc_hi++;
        if (rsp_valid && !prev_rv) rise_cyc = cyc_n;
        prev_rv = rsp_valid;
    end

    task automatic send_cmd(input logic we, input logic [7:0] adr, input logic [31:0] dat);
        bit done = 0;
        @(negedge wb_clk_i);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cyc_hi = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            if (cmd_ready) begin
                @(posedge wb_clk_i);
                #2 acc_cyc = cyc_n;
                done = 1;
            end else begin
                @(negedge wb_clk_i);
            end
        end
        chk("cmd_accepted", 32'(done), 32'd1);
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int hold, input bit stray,
                            output logic [31:0] dat, output logic err);
        bit seen = 0;
        rsp_ready = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (rsp_valid) seen = 1;
            else begin
                chk("busy_cmd_ready", cmd_ready, 32'd0);
                @(negedge wb_clk_i);
            end
        end
        chk("rsp_within_bound", 32'(seen), 32'd1);
        dat = rsp_dat;
        err = rsp_err;
        for (int k = 0; k < hold && seen; k++) begin
            stray_ack = stray && (k % 2 == 0);
            @(negedge wb_clk_i);
            chk("hold_rsp_valid", rsp_valid, 32'd1);
            chk("hold_rsp_dat",   rsp_dat,   dat);
            chk("hold_cmd_ready", cmd_ready, 32'd0);
        end
        stray_ack = 1'b0;
        rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
    endtask

    logic [31:0] r_dat;
    logic        r_err;

    initial begin
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        chk("reset_cmd_ready", cmd_ready, 32'd1);
        chk("reset_cyc",       wb_cyc_o,  32'd0);
        chk("reset_rsp_valid", rsp_valid, 32'd0);
        chk("reset_irq",       irq_pending, 32'd0);

        // Write with ack in the second strobe cycle
        send_cmd(1'b1, XGE_ADR_CONFIG0, 32'h0000_0001);
        wait_rsp(0, 1'b0, r_dat, r_err);
        chk("wr_cyc_cycles",   32'(cyc_hi), 32'd2);
        chk("wr_rsp_latency",  32'(rise_cyc - acc_cyc), 32'd2);
        chk("wr_rsp_err",      r_err, 32'd0);
        chk("wr_rsp_dat",      r_dat, 32'd0);

        // Read back
        send_cmd(1'b0, XGE_ADR_CONFIG0, 32'hDEAD_BEEF);
        wait_rsp(0, 1'b0, r_dat, r_err);
        chk("rd_rsp_dat", r_dat, 32'h0000_0001);
        chk("rd_rsp_err", r_err, 32'd0);

        // Timeout: slave silent
        ack_en = 1'b0;
        send_cmd(1'b1, XGE_ADR_INT_MASK, 32'h0000_FFFF);
        wait_rsp(0, 1'b0, r_dat, r_err);
        chk("tmo_cyc_cycles", 32'(cyc_hi), 32'd16);
        chk("tmo_rsp_err",    r_err, 32'd1);
        chk("tmo_rsp_dat",    r_dat, 32'd0);
        ack_en = 1'b1;
        send_cmd(1'b0, XGE_ADR_INT_MASK, 32'h0);
        wait_rsp(0, 1'b0, r_dat, r_err);
        chk("post_tmo_rd", r_dat, 32'hA500_0010);
        chk("post_tmo_err", r_err, 32'd0);

        // Backpressure with stray acks during the response phase
        send_cmd(1'b0, XGE_ADR_INT_STATUS, 32'h0);
        wait_rsp(5, 1'b1, r_dat, r_err);
        chk("bp_rsp_dat",     r_dat, 32'hA500_000C);
        chk("bp_single_cycle", 32'(cyc_hi), 32'd2);

        // Interrupt: rise, clear while held high, then simultaneous rise and clear
        @(negedge wb_clk_i);
        wb_int_i = 1'b1;
        @(negedge wb_clk_i);
        chk("irq_set", irq_pending, 32'd1);
        repeat (2) @(negedge wb_clk_i);
        irq_clr = 1'b1;
        @(negedge wb_clk_i);
        irq_clr = 1'b0;
        chk("irq_cleared", irq_pending, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge wb_clk_i);
            chk("irq_level_no_reset", irq_pending, 32'd0);
        end
        wb_int_i = 1'b0;
        @(negedge wb_clk_i);
        wb_int_i = 1'b1;
        irq_clr  = 1'b1;
        @(negedge wb_clk_i);
        irq_clr  = 1'b0;
        chk("irq_set_wins", irq_pending, 32'd1);
        @(negedge wb_clk_i);
        chk("irq_sticky", irq_pending, 32'd1);
        wb_int_i = 1'b0;
        irq_clr  = 1'b1;
        @(negedge wb_clk_i);
        irq_clr  = 1'b0;

        // Reset mid-transfer
        ack_en = 1'b0;
        send_cmd(1'b0, XGE_ADR_INT_PENDING, 32'h0);
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        chk("rst_bus_cyc",       wb_cyc_o,  32'd0);
        chk("rst_bus_stb",       wb_stb_o,  32'd0);
        chk("rst_bus_rsp_valid", rsp_valid, 32'd0);
        wb_rst_i = 1'b0;
        ack_en   = 1'b1;
        @(negedge wb_clk_i);
        chk("rst_bus_cmd_ready", cmd_ready, 32'd1);

        send_cmd(1'b0, XGE_ADR_INT_PENDING, 32'h0);
        wait_rsp(0, 1'b0, r_dat, r_err);
        chk("post_rst_rd", r_dat, 32'hA500_0008);

        repeat (3) @(negedge wb_clk_i);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xge_wb_cfg_master.md
Name: xge_wb_cfg_master

Overview:
Wishbone classic single-transfer master (initiator) that drives the xge_mac Wishbone register slave. It accepts register read and write commands on a valid/ready command port and runs one bus cycle per command. Each cycle ends in a response on a valid/ready response port, with a bus timeout if the slave never acks. It also latches the slave interrupt line into a sticky pending flag for the config/control logic.

Parameters:
ADR_W, 8, Wishbone address width
DAT_W, 32, Wishbone data width
TIMEOUT_CYCLES, 64, max cycles cyc/stb stay asserted without ack (legal range 2..1024)

Ports:
wb_clk_i  in  1  single clock for all logic
wb_rst_i  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  master can accept command
cmd_we  in  1  1=write, 0=read
cmd_adr  in  ADR_W  register address
cmd_dat  in  DAT_W  write data (ignored for reads)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_dat  out  DAT_W  read data (0 for writes and timeouts)
rsp_err  out  1  1 = bus timeout
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_adr_o  out  ADR_W  Wishbone address
wb_dat_o  out  DAT_W  Wishbone write data
wb_dat_i  in  DAT_W  Wishbone read data
wb_ack_i  in  1  Wishbone acknowledge
wb_int_i  in  1  slave interrupt (level)
irq_pending  out  1  sticky interrupt flag
irq_clr  in  1  clears irq_pending

Behaviour:
- One clock wb_clk_i; synchronous active-high reset wb_rst_i. All outputs are registered except cmd_ready.
- Reset values: state IDLE; cyc/stb/we = 0; adr/dat_o = 0; rsp_valid = 0; rsp_dat = 0; rsp_err = 0; irq_pending = 0; timeout counter = 0.
- FSM states are IDLE, BUS and RESP.
- IDLE:
  - cmd_ready = 1.
  - When cmd_valid is 1, register cmd_we/cmd_adr/cmd_dat onto wb_we_o/wb_adr_o/wb_dat_o, assert cyc/stb at the next edge and go to BUS.
  - Acceptance at edge N means cyc/stb are high during cycle N+1.
- BUS:
  - cmd_ready = 0; cyc/stb/adr/we/dat_o stay stable.
  - Counter increments each cycle.
  - If wb_ack_i = 1 at edge M: drop cyc/stb/we at M; capture wb_dat_i into rsp_dat for reads (0 for writes); set rsp_err = 0 and rsp_valid = 1; go to RESP.
  - Single-cycle ack slave: rsp_valid rises 2 cycles after command acceptance.
  - If no ack and the counter reaches TIMEOUT_CYCLES-1: drop cyc/stb; set rsp_dat = 0, rsp_err = 1, rsp_valid = 1; go to RESP. cyc is high for exactly TIMEOUT_CYCLES cycles.
  - If ack and timeout coincide, ack wins (rsp_err = 0).
- RESP:
  - cmd_ready = 0.
  - rsp_valid/rsp_dat/rsp_err hold until rsp_valid & rsp_ready.
  - On that handshake: clear rsp_valid, clear the counter, go to IDLE. The next command is accepted one cycle later, so there are no back-to-back bus cycles.
- wb_ack_i is ignored outside BUS (stray ack has no effect).
- wb_dat_o/wb_adr_o keep their last values after a cycle ends; only cyc/stb/we are cleared.
- Interrupt:
  - irq_pending is set on a sampled 0→1 transition of wb_int_i (one register stage of history).
  - irq_clr clears it.
  - If a set and a clear occur in the same cycle, set wins.
  - wb_int_i held high after a clear does not re-set irq_pending; only a new rising edge does.
- Reset mid-operation (BUS or RESP): cyc/stb drop and rsp_valid clears at that edge, with no response issued. The command is lost and the requester must reissue.

Decomposition:
- Shared package xge_wb_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUS, RESP} wb_mst_state_t;
  - the xge_mac register address constants (config, int pending, int status, int mask), reused by the testbench sequences.
- No sub-module: the timeout counter and interrupt edge detector are inline.

Test Plan:
- Write: cmd(we=1, adr=8'h00, dat=32'h0000_0001), slave acks one cycle after stb → cyc high exactly 2 cycles; rsp_valid 2 cycles after accept; rsp_err=0, rsp_dat=0.
- Read: cmd(we=0, adr=8'h00) after the write above → rsp_dat=32'h0000_0001, rsp_err=0; cmd_ready low from accept until the rsp handshake.
- Timeout: TIMEOUT_CYCLES=16, slave never acks → cyc high exactly 16 cycles, then rsp_err=1, rsp_dat=0. A further command is accepted normally.
- Backpressure: rsp_ready held low 5 cycles, stray ack pulses in RESP → rsp fields stable 5 cycles; no second bus cycle; cmd_ready=0 throughout.
- Interrupt: wb_int_i rises and stays high, irq_clr pulsed after 3 cycles → irq_pending=1, then 0, and stays 0 until wb_int_i falls and rises again. Simultaneous rise and clr → irq_pending=1.
- Reset in BUS: assert wb_rst_i 1 cycle mid-transfer → cyc/stb=0, rsp_valid=0 next edge; cmd_ready=1 after reset release.
